div_32x16_seq: RTL

DIV_32X16_SEQ -- requirements
Module: div_32x16_seq

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 34 +++
 rtl/div_32x16_seq.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential 2N/N unsigned divider.
//   QW      : default quotient / remainder / divisor width (dividend is 2*QW)
//   state_e : control FSM states
// ----------------------------------------------------------------------------
package div_pkg;

  localparam int QW = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

endpackage

// File: rtl/div_step.sv
// ----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration.
// Ports:
//   rem_i     : current partial remainder (always < divisor_i)
//   bit_i     : next dividend bit, shifted in at the LSB
//   divisor_i : divisor
//   rem_o     : new partial remainder
//   qbit_o    : quotient bit produced by this iteration
// ----------------------------------------------------------------------------
module div_step #(
  parameter int QW = div_pkg::QW
) (
  input  logic [QW-1:0] rem_i,
  input  logic          bit_i,
  input  logic [QW-1:0] divisor_i,
  output logic [QW-1:0] rem_o,
  output logic          qbit_o
);

  logic [QW:0] shifted;
  logic [QW:0] trial;

  // Because rem_i < divisor_i, the shifted value is < 2*divisor, so a
  // non-negative trial difference always fits back into QW bits and a
  // negative one means the shifted value itself fits in QW bits.
  always_comb begin
    shifted = {rem_i, bit_i};
    trial   = shifted - {1'b0, divisor_i};
    qbit_o  = ~trial[QW];
    rem_o   = qbit_o ? trial[QW-1:0] : shifted[QW-1:0];
  end

endmodule

// File: rtl/div_32x16_seq.sv
// ----------------------------------------------------------------------------
// div_32x16_seq
// Sequential unsigned divider: 2*QW-bit dividend by QW-bit divisor, one
// quotient bit per clock (restoring, MSB first), valid/ready on both sides.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (ready only while idle)
//   dividend, divisor   : unsigned operands, captured at the accept edge
//   out_valid/out_ready : result handshake (valid only while done)
//   quotient, remainder : result, held until the result is taken
//   div_by_zero         : divisor was zero
//   overflow            : quotient would not fit in QW bits
// ----------------------------------------------------------------------------
module div_32x16_seq #(
  parameter int QW = div_pkg::QW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*QW-1:0] dividend,
  input  logic [QW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [QW-1:0]   quotient,
  output logic [QW-1:0]   remainder,
  output logic            div_by_zero,
  output logic            overflow
);

  import div_pkg::*;

  localparam int CW = $clog2(QW) + 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [QW-1:0]   rem_q, rem_d;
  logic [QW-1:0]   shift_q, shift_d;
  logic [QW-1:0]   dvs_q, dvs_d;
  logic [QW-1:0]   quot_q, quot_d;
  logic [QW-1:0]   remOut_q, remOut_d;
  logic            dbz_q, dbz_d;
  logic            ovf_q, ovf_d;

  logic            accept;
  logic            isZero;
  logic            isOvf;
  logic            lastIter;
  logic [QW-1:0]   stepRem;
  logic            stepQbit;

  assign accept   = in_valid && in_ready;
  assign isZero   = (divisor == '0);
  assign isOvf    = !isZero && (dividend[2*QW-1:QW] >= divisor);
  assign lastIter = (cnt_q == CW'(QW - 1));

  div_step #(.QW(QW)) u_step (
    .rem_i     (rem_q),
    .bit_i     (shift_q[QW-1]),
    .divisor_i (dvs_q),
    .rem_o     (stepRem),
    .qbit_o    (stepQbit)
  );

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. Exceptions skip the iteration phase entirely.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = (isZero || isOvf) ? DONE : BUSY;
      BUSY: if (lastIter) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state alone.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath next-state. The low dividend half shifts out of shift_q MSB
  // first while quotient bits fill it from the LSB, so after QW steps it
  // holds the quotient. Result registers only change when entering DONE,
  // which keeps the outputs steady at all other times.
  always_comb begin
    rem_d    = rem_q;
    shift_d  = shift_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    quot_d   = quot_q;
    remOut_d = remOut_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    if (accept) begin
      cnt_d = '0;
      if (isZero || isOvf) begin
        quot_d   = '1;
        remOut_d = dividend[QW-1:0];
        dbz_d    = isZero;
        ovf_d    = isOvf;
      end else begin
        rem_d   = dividend[2*QW-1:QW];
        shift_d = dividend[QW-1:0];
        dvs_d   = divisor;
      end
    end else if (state_q == BUSY) begin
      rem_d   = stepRem;
      shift_d = {shift_q[QW-2:0], stepQbit};
      cnt_d   = cnt_q + CW'(1);
      if (lastIter) begin
        quot_d   = {shift_q[QW-2:0], stepQbit};
        remOut_d = stepRem;
        dbz_d    = 1'b0;
        ovf_d    = 1'b0;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q    <= '0;
      shift_q  <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      quot_q   <= '0;
      remOut_q <= '0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      shift_q  <= shift_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      quot_q   <= quot_d;
      remOut_q <= remOut_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = remOut_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
